// File: rtl/rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_if
//
// Bundles the request / grant signals of the rr_arbiter so that requesters and
// the arbiter can be connected with a single port.
//
// Signals:
//   req        NUM_REQ    request vector, bit i belongs to requester i
//   rr_mode    1          1 = round-robin, 0 = fixed priority (highest index)
//   gnt        NUM_REQ    one-hot registered grant (all zero when idle)
//   gnt_idx    IDX_WIDTH  binary index of the granted requester
//   gnt_valid  1          a grant is active
//   preempt    1          one-cycle pulse when a grant was ended by the hold limit
//
// Modports:
//   master  requester side: drives req / rr_mode, observes the grant
//   slave   arbiter side:   observes req / rr_mode, drives the grant
// -----------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int NUM_REQ   = 16,
  parameter int IDX_WIDTH = 4
);

  logic [NUM_REQ-1:0]   req;
  logic                 rr_mode;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic                 gnt_valid;
  logic                 preempt;

  modport master (
    output req,
    output rr_mode,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    input  rr_mode,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );

endinterface : rr_arbiter_if

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// N-way arbiter with a registered grant. A requester keeps the grant for as
// long as it holds its request bit. Winner selection is either fixed priority
// (highest index wins) or round-robin (first requester after the previous
// winner), chosen by rr_mode at the moment a new winner is picked.
//
// While the owner holds the grant and somebody else is waiting, a hold counter
// runs. When it reaches MAX_HOLD the owner is preempted: it is excluded from
// the next arbitration, the next winner is granted at the following edge and
// preempt pulses for that one cycle. MAX_HOLD = 0 disables preemption.
//
// When the owner releases while others are waiting, the next winner is chosen
// in the same cycle, so the hand-over has no idle bubble.
//
// Ports:
//   clk   in   clock, all state changes on the rising edge
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of rr_arbiter_if (req, rr_mode in; gnt, gnt_idx,
//         gnt_valid, preempt out, all outputs registered)
//
// Parameters:
//   NUM_REQ    number of requesters, 2..32
//   IDX_WIDTH  ceil(log2(NUM_REQ))
//   MAX_HOLD   max consecutive grant cycles while another requester waits
//   CNT_WIDTH  hold counter width, 2**CNT_WIDTH > MAX_HOLD
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ   = 16,
  parameter int IDX_WIDTH = 4,
  parameter int MAX_HOLD  = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] PTR_RESET = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(MAX_HOLD);
  localparam logic [NUM_REQ-1:0]   ONE_HOT_0 = NUM_REQ'(1);
  localparam bit                   LIMIT_ON  = (MAX_HOLD != 0);

  // ---------------------------------------------------------------------------
  // Winner selection helpers
  // ---------------------------------------------------------------------------

  // Highest-index set bit; later iterations overwrite earlier ones.
  function automatic logic [IDX_WIDTH-1:0] pick_fixed(
    input logic [NUM_REQ-1:0] v
  );
    logic [IDX_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) w = IDX_WIDTH'(i);
    end
    return w;
  endfunction

  // First set bit searching upward from ptr+1 with wrap-around. The loop walks
  // the circular order backwards so the candidate closest after ptr is the
  // last one written. ptr itself is visited last (offset NUM_REQ).
  function automatic logic [IDX_WIDTH-1:0] pick_rr(
    input logic [NUM_REQ-1:0]   v,
    input logic [IDX_WIDTH-1:0] ptr
  );
    logic [IDX_WIDTH-1:0] w;
    int                   j;
    w = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (v[j]) w = IDX_WIDTH'(j);
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q,     state_d;
  logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
  logic [IDX_WIDTH-1:0] gnt_idx_q,   gnt_idx_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 preempt_q,   preempt_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q,  hold_cnt_d;
  logic [IDX_WIDTH-1:0] ptr_q,       ptr_d;

  // ---------------------------------------------------------------------------
  // Request decode relative to the current owner
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]   others;
  logic                 owner_req;
  logic                 others_pend;
  logic                 hold_at_max;
  logic                 preempt_cond;

  // gnt_q is one-hot (or zero), so masking with it avoids indexing req with a
  // value that could exceed NUM_REQ-1 for non power-of-two sizes.
  assign owner_req    = |(bus.req & gnt_q);
  assign others       = bus.req & ~gnt_q;
  assign others_pend  = |others;
  assign hold_at_max  = (hold_cnt_q == HOLD_MAX);
  assign preempt_cond = LIMIT_ON && hold_at_max && others_pend && owner_req;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic                 arb_en;
  logic [NUM_REQ-1:0]   cand;
  logic [IDX_WIDTH-1:0] win;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    arb_en      = 1'b0;
    cand        = '0;
    win         = '0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          arb_en = 1'b1;
          cand   = bus.req;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Release: a release on the limit cycle lands here, so it is a
          // plain hand-over and never raises preempt.
          if (others_pend) begin
            arb_en = 1'b1;
            cand   = others;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (preempt_cond) begin
          // The owner is left out of the candidates, which in fixed mode lets
          // lower priorities through for this one arbitration.
          arb_en    = 1'b1;
          cand      = others;
          preempt_d = 1'b1;
        end else if (others_pend && !hold_at_max) begin
          hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // rr_mode only matters here, so toggling it mid-grant has no effect.
    if (arb_en) begin
      win         = bus.rr_mode ? pick_rr(cand, ptr_q) : pick_fixed(cand);
      state_d     = GRANT;
      gnt_d       = ONE_HOT_0 << win;
      gnt_idx_d   = win;
      gnt_valid_d = 1'b1;
      ptr_d       = win;
      hold_cnt_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= PTR_RESET;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//
// Three arbiter instances:
//   u_a  16 requesters, MAX_HOLD 15  (reset, fixed priority, round-robin walk,
//                                     single-requester release / re-request)
//   u_b  16 requesters, MAX_HOLD 3   (hold-limit preemption)
//   u_c   5 requesters, MAX_HOLD 3   (random traffic, invariants, starvation)
// Directed steps push their expected grant into a queue when the request is
// driven; the entry is popped and compared after the next rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_if #(.NUM_REQ(16), .IDX_WIDTH(4)) bus_a ();
  rr_arbiter_if #(.NUM_REQ(16), .IDX_WIDTH(4)) bus_b ();
  rr_arbiter_if #(.NUM_REQ(5),  .IDX_WIDTH(3)) bus_c ();

  rr_arbiter #(.NUM_REQ(16), .IDX_WIDTH(4), .MAX_HOLD(15), .CNT_WIDTH(4)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  rr_arbiter #(.NUM_REQ(16), .IDX_WIDTH(4), .MAX_HOLD(3), .CNT_WIDTH(2)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  rr_arbiter #(.NUM_REQ(5), .IDX_WIDTH(3), .MAX_HOLD(3), .CNT_WIDTH(2)) u_c (
    .clk (clk),
    .rst (rst_c),
    .bus (bus_c)
  );

  typedef struct {
    string       tag;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic        pre;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int which, input string tag);
    if (which == 0) begin
      chk({tag, ".gnt"},   32'(bus_a.gnt),       32'h0);
      chk({tag, ".idx"},   32'(bus_a.gnt_idx),   32'h0);
      chk({tag, ".valid"}, 32'(bus_a.gnt_valid), 32'h0);
      chk({tag, ".pre"},   32'(bus_a.preempt),   32'h0);
    end else if (which == 1) begin
      chk({tag, ".gnt"},   32'(bus_b.gnt),       32'h0);
      chk({tag, ".idx"},   32'(bus_b.gnt_idx),   32'h0);
      chk({tag, ".valid"}, 32'(bus_b.gnt_valid), 32'h0);
      chk({tag, ".pre"},   32'(bus_b.preempt),   32'h0);
    end else begin
      chk({tag, ".gnt"},   32'(bus_c.gnt),       32'h0);
      chk({tag, ".idx"},   32'(bus_c.gnt_idx),   32'h0);
      chk({tag, ".valid"}, 32'(bus_c.gnt_valid), 32'h0);
      chk({tag, ".pre"},   32'(bus_c.preempt),   32'h0);
    end
  endtask

  // Pop the oldest expectation and compare it with the selected instance.
  task automatic check_out(input int which);
    exp_t        e;
    logic [15:0] g;
    logic [3:0]  ix;
    logic        v;
    logic        p;
    chk("sb.nonempty", 32'(sb_q.size() != 0), 32'h1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (which == 0) begin
      g = bus_a.gnt; ix = bus_a.gnt_idx; v = bus_a.gnt_valid; p = bus_a.preempt;
    end else begin
      g = bus_b.gnt; ix = bus_b.gnt_idx; v = bus_b.gnt_valid; p = bus_b.preempt;
    end
    chk({e.tag, ".gnt"},   32'(g),  32'(e.gnt));
    chk({e.tag, ".idx"},   32'(ix), 32'(e.idx));
    chk({e.tag, ".valid"}, 32'(v),  32'(e.valid));
    chk({e.tag, ".pre"},   32'(p),  32'(e.pre));
  endtask

  // Drive one cycle of request on instance 0 (u_a) or 1 (u_b), record what the
  // grant must be after the next edge, then compare.
  task automatic step(input int which, input logic [15:0] r, input logic mode,
                      input string tag, input int exp_idx, input logic exp_valid,
                      input logic exp_pre);
    exp_t e;
    if (which == 0) begin
      bus_a.req = r; bus_a.rr_mode = mode;
    end else begin
      bus_b.req = r; bus_b.rr_mode = mode;
    end
    e.tag   = tag;
    e.valid = exp_valid;
    e.idx   = exp_valid ? 4'(exp_idx) : 4'h0;
    e.gnt   = exp_valid ? (16'h1 << exp_idx) : 16'h0;
    e.pre   = exp_pre;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(which);
  endtask

  localparam int C_N     = 5;
  localparam int C_BOUND = (C_N - 1) * (3 + 1) + 1;

  logic [4:0] rreq;
  logic [4:0] g5;
  int         wait_cnt [C_N];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.req = '0; bus_a.rr_mode = 1'b0;
    bus_b.req = '0; bus_b.rr_mode = 1'b0;
    bus_c.req = '0; bus_c.rr_mode = 1'b1;
    rreq = '0;
    for (int i = 0; i < C_N; i++) wait_cnt[i] = 0;

    // ---- 1: reset state, first grant latency, asynchronous reset mid-grant
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "a.reset");
    rst_a = 1'b1;
    step(0, 16'h0001, 1'b0, "t1.first", 0, 1'b1, 1'b0);
    step(0, 16'h0001, 1'b0, "t1.hold", 0, 1'b1, 1'b0);
    #2 rst_a = 1'b0;
    #1 chk_zero(0, "t1.async_rst");
    @(posedge clk);
    #1 rst_a = 1'b1;

    // ---- 2: fixed priority, release hand-over with no bubble, mode toggle
    step(0, 16'h8421, 1'b0, "t2.win15", 15, 1'b1, 1'b0);
    step(0, 16'h8421, 1'b1, "t2.toggle_hold", 15, 1'b1, 1'b0);
    step(0, 16'h0421, 1'b0, "t2.win10", 10, 1'b1, 1'b0);
    step(0, 16'h0021, 1'b0, "t2.win5", 5, 1'b1, 1'b0);
    step(0, 16'h0000, 1'b0, "t2.idle", 0, 1'b0, 1'b0);

    // ---- 3: round-robin walk over all 16 with wrap to 0
    rst_a = 1'b0;
    @(posedge clk);
    #1 chk_zero(0, "t3.reset");
    rst_a = 1'b1;
    step(0, 16'hFFFF, 1'b1, "t3.first", 0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(0, 16'hFFFF, 1'b1, $sformatf("t3.hold%0d", k), k, 1'b1, 1'b0);
      step(0, 16'hFFFF & ~(16'h1 << k), 1'b1, $sformatf("t3.next%0d", k),
           (k + 1) % 16, 1'b1, 1'b0);
    end

    // ---- 5: single requester release and re-request
    step(0, 16'h0000, 1'b1, "t5.drain", 0, 1'b0, 1'b0);
    step(0, 16'h0040, 1'b1, "t5.grant", 6, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step(0, 16'h0040, 1'b1, $sformatf("t5.hold%0d", k), 6, 1'b1, 1'b0);
    step(0, 16'h0000, 1'b1, "t5.release", 0, 1'b0, 1'b0);
    step(0, 16'h0040, 1'b1, "t5.regrant", 6, 1'b1, 1'b0);
    step(0, 16'h0000, 1'b1, "t5.release2", 0, 1'b0, 1'b0);

    // ---- 4: hold-limit preemption with MAX_HOLD = 3
    chk_zero(1, "b.reset");
    rst_b = 1'b1;
    step(1, 16'h0003, 1'b1, "t4.rr_g0", 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1, 16'h0003, 1'b1, $sformatf("t4.rr_h0_%0d", k), 0, 1'b1, 1'b0);
    step(1, 16'h0003, 1'b1, "t4.rr_pre1", 1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      step(1, 16'h0003, 1'b1, $sformatf("t4.rr_h1_%0d", k), 1, 1'b1, 1'b0);
    step(1, 16'h0003, 1'b1, "t4.rr_pre0", 0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      step(1, 16'h0003, 1'b1, $sformatf("t4.rr_h0b_%0d", k), 0, 1'b1, 1'b0);
    step(1, 16'h0002, 1'b1, "t4.rel_on_limit", 1, 1'b1, 1'b0);
    step(1, 16'h0002, 1'b1, "t4.alone", 1, 1'b1, 1'b0);
    step(1, 16'h0000, 1'b1, "t4.idle", 0, 1'b0, 1'b0);
    step(1, 16'h0003, 1'b0, "t4.fx_g1", 1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1, 16'h0003, 1'b0, $sformatf("t4.fx_h1_%0d", k), 1, 1'b1, 1'b0);
    step(1, 16'h0003, 1'b0, "t4.fx_pre0", 0, 1'b1, 1'b1);
    step(1, 16'h0003, 1'b0, "t4.fx_h0", 0, 1'b1, 1'b0);
    step(1, 16'h0000, 1'b0, "t4.fx_idle", 0, 1'b0, 1'b0);

    // ---- 6: five requesters, random sticky traffic in round-robin mode
    chk_zero(2, "c.reset");
    rst_c = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < C_N; i++)
        if ($urandom_range(7) == 0) rreq[i] = ~rreq[i];
      bus_c.req = rreq;
      @(posedge clk);
      #1;
      g5 = bus_c.gnt;
      chk("t6.onehot", 32'((g5 & (g5 - 5'd1)) == 5'd0), 32'h1);
      chk("t6.valid_or", 32'(bus_c.gnt_valid), 32'(|g5));
      chk("t6.idx_range", 32'(bus_c.gnt_idx < 3'd5), 32'h1);
      chk("t6.idx_match", 32'(g5),
          bus_c.gnt_valid ? (32'h1 << bus_c.gnt_idx) : 32'h0);
      for (int i = 0; i < C_N; i++) begin
        if (rreq[i] && !g5[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk($sformatf("t6.starve%0d", i), 32'(wait_cnt[i] <= C_BOUND), 32'h1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_arbiter
